// File: rtl/mcp4922_rx.sv
// Receive-side decoder for the MCP4922 dual 12-bit DAC SPI interface.
// Optional macro MCP4922_RX_LDAC_EN enables the ldac_n latch; otherwise outputs follow each accepted frame.
module mcp4922_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        sdi,
  input  logic        cs_n,
  input  logic        ldac_n,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic        gain2_a,
  output logic        gain2_b,
  output logic        shdn_a,
  output logic        shdn_b,
  output logic        frame_valid,
  output logic        frame_axis,
  output logic        frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_sdi_sync, r_cs_sync;
  logic                   r_sck_d, r_cs_d;
  logic                   w_sck_s, w_sdi_s, w_cs_s;
  logic                   w_sck_rise, w_cs_fall, w_cs_rise;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic [15:0] r_sr;
  logic        w_clear, w_shift, w_accept, w_reject, w_xfer;

  logic [11:0] r_in_a_data, r_in_b_data, w_in_a_data, w_in_b_data;
  logic        r_in_a_gain, r_in_b_gain, w_in_a_gain, w_in_b_gain;
  logic        r_in_a_shdn, r_in_b_shdn, w_in_a_shdn, w_in_b_shdn;

  // cs_n chain resets low so that a line already low at release never looks like a frame start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sck_sync <= '0;
      r_sdi_sync <= '0;
      r_cs_sync  <= '0;
      r_sck_d    <= 1'b0;
      r_cs_d     <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sck_d    <= w_sck_s;
      r_cs_d     <= w_cs_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi_s    = r_sdi_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_cs_fall  = ~w_cs_s & r_cs_d;
  assign w_cs_rise  = w_cs_s & ~r_cs_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_shift     = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = S_SHIFT;
          w_clear     = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_cs_rise) w_state_nxt = S_DONE;
        else if (w_sck_rise && !w_cs_s) w_shift = 1'b1;
      end
      S_DONE: begin
        w_accept = (r_cnt == 5'd16);
        w_reject = (r_cnt != 5'd16);
        if (w_cs_fall) begin
          w_state_nxt = S_SHIFT;
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 5'd0;
      r_sr  <= 16'd0;
    end else if (w_clear) begin
      r_cnt <= 5'd0;
      r_sr  <= 16'd0;
    end else if (w_shift) begin
      r_sr <= {r_sr[14:0], w_sdi_s};
      if (r_cnt < 5'd17) r_cnt <= r_cnt + 5'd1;
    end
  end

  // Bit 15 channel, 14 BUF (ignored), 13 GA_n, 12 SHDN_n, 11:0 data
  always_comb begin
    w_in_a_data = r_in_a_data;
    w_in_a_gain = r_in_a_gain;
    w_in_a_shdn = r_in_a_shdn;
    w_in_b_data = r_in_b_data;
    w_in_b_gain = r_in_b_gain;
    w_in_b_shdn = r_in_b_shdn;
    if (w_accept) begin
      if (r_sr[15]) begin
        w_in_b_data = r_sr[11:0];
        w_in_b_gain = ~r_sr[13];
        w_in_b_shdn = ~r_sr[12];
      end else begin
        w_in_a_data = r_sr[11:0];
        w_in_a_gain = ~r_sr[13];
        w_in_a_shdn = ~r_sr[12];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_a_data <= 12'd0;
      r_in_a_gain <= 1'b0;
      r_in_a_shdn <= 1'b0;
      r_in_b_data <= 12'd0;
      r_in_b_gain <= 1'b0;
      r_in_b_shdn <= 1'b0;
    end else begin
      r_in_a_data <= w_in_a_data;
      r_in_a_gain <= w_in_a_gain;
      r_in_a_shdn <= w_in_a_shdn;
      r_in_b_data <= w_in_b_data;
      r_in_b_gain <= w_in_b_gain;
      r_in_b_shdn <= w_in_b_shdn;
    end
  end

`ifdef MCP4922_RX_LDAC_EN
  logic [SYNC_STAGES-1:0] r_ldac_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ldac_sync <= '1;
    else        r_ldac_sync <= {r_ldac_sync[SYNC_STAGES-2:0], ldac_n};
  end

  assign w_xfer = ~r_ldac_sync[SYNC_STAGES-1];
`else
  logic w_unused_ldac;

  assign w_unused_ldac = ldac_n;
  assign w_xfer        = w_accept;
`endif

  // Outputs copy the next-state input registers so a same-cycle accept is seen immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dac_a       <= 12'd0;
      dac_b       <= 12'd0;
      gain2_a     <= 1'b0;
      gain2_b     <= 1'b0;
      shdn_a      <= 1'b0;
      shdn_b      <= 1'b0;
      frame_valid <= 1'b0;
      frame_axis  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= w_accept;
      frame_err   <= w_reject;
      if (w_accept) frame_axis <= r_sr[15];
      if (w_xfer) begin
        dac_a   <= w_in_a_data;
        dac_b   <= w_in_b_data;
        gain2_a <= w_in_a_gain;
        gain2_b <= w_in_b_gain;
        shdn_a  <= w_in_a_shdn;
        shdn_b  <= w_in_b_shdn;
      end
    end
  end

endmodule

// File: tb/tb_mcp4922_rx.sv
// Randomized bench for mcp4922_rx against a frame-level reference model.
module tb_mcp4922_rx;
  localparam int SS = 2;
  localparam int H  = SS + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        cs_n = 1'b1;
  logic        ldac_n = 1'b0;
  logic [11:0] dac_a, dac_b;
  logic        gain2_a, gain2_b, shdn_a, shdn_b;
  logic        frame_valid, frame_axis, frame_err;

  mcp4922_rx #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n), .ldac_n(ldac_n),
    .dac_a(dac_a), .dac_b(dac_b), .gain2_a(gain2_a), .gain2_b(gain2_b),
    .shdn_a(shdn_a), .shdn_b(shdn_b), .frame_valid(frame_valid),
    .frame_axis(frame_axis), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (frame_valid) n_valid++;
    if (frame_err) n_err++;
  end

  logic [11:0] m_in_d [2];
  logic        m_in_g [2];
  logic        m_in_s [2];
  logic [11:0] m_out_d [2];
  logic        m_out_g [2];
  logic        m_out_s [2];
  logic        m_axis;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_in_d[c] = 12'd0; m_in_g[c] = 1'b0; m_in_s[c] = 1'b0;
      m_out_d[c] = 12'd0; m_out_g[c] = 1'b0; m_out_s[c] = 1'b0;
    end
    m_axis = 1'b0;
  endtask

  task automatic model_xfer();
    for (int c = 0; c < 2; c++) begin
      m_out_d[c] = m_in_d[c]; m_out_g[c] = m_in_g[c]; m_out_s[c] = m_in_s[c];
    end
  endtask

  function automatic bit latch_open();
`ifdef MCP4922_RX_LDAC_EN
    return (ldac_n == 1'b0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_outs(input string tag);
    chk_val({tag, "_dac_a"}, {20'd0, dac_a}, {20'd0, m_out_d[0]});
    chk_val({tag, "_dac_b"}, {20'd0, dac_b}, {20'd0, m_out_d[1]});
    chk_val({tag, "_gain2"}, {30'd0, gain2_a, gain2_b}, {30'd0, m_out_g[0], m_out_g[1]});
    chk_val({tag, "_shdn"}, {30'd0, shdn_a, shdn_b}, {30'd0, m_out_s[0], m_out_s[1]});
    chk_val({tag, "_axis"}, {31'd0, frame_axis}, {31'd0, m_axis});
  endtask

  task automatic set_ldac(input logic v);
    ldac_n = v;
    cyc(SS + 3);
    if (latch_open()) model_xfer();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(3);
    model_reset();
    reset = 1'b1;
    cyc(SS + 3);
  endtask

  task automatic send_frame(input string tag, input logic [16:0] w, input int nbits);
    int v0, e0, lat, ch;
    logic [23:0] dac_at;
    bit acc;
    v0 = n_valid;
    e0 = n_err;
    cs_n = 1'b0;
    cyc(H);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = w[i];
      cyc(H);
      sck = 1'b1;
      cyc(H);
      sck = 1'b0;
    end
    cyc(H);
    cs_n = 1'b1;
    lat = 0;
    dac_at = 24'd0;
    for (int k = 1; k <= SS + 6; k++) begin
      @(negedge clk);
      if ((frame_valid || frame_err) && lat == 0) begin
        lat = k;
        dac_at = {dac_a, dac_b};
      end
    end
    acc = (nbits == 16);
    if (acc) begin
      ch = int'(w[15]);
      m_in_d[ch] = w[11:0];
      m_in_g[ch] = ~w[13];
      m_in_s[ch] = ~w[12];
      m_axis = w[15];
      if (latch_open()) model_xfer();
    end
    chk_val({tag, "_pulse_lat"}, lat, SS + 2);
    cyc(3);
    chk_val({tag, "_valid_cnt"}, n_valid - v0, {31'd0, acc});
    chk_val({tag, "_err_cnt"}, n_err - e0, {31'd0, !acc});
    if (acc && latch_open())
      chk_val({tag, "_dac_at_pulse"}, {8'd0, dac_at}, {8'd0, m_out_d[0], m_out_d[1]});
    check_outs(tag);
  endtask

  initial begin
    int v0, e0, nb;
    logic [16:0] w;
    model_reset();
    cyc(3);
    check_outs("reset");
    chk_val("reset_pulses", {30'd0, frame_valid, frame_err}, 32'd0);
    reset = 1'b1;
    cyc(SS + 3);

    send_frame("chA", 17'h03ABC, 16);
    send_frame("chB", 17'h08123, 16);
    send_frame("short", 17'h05A5A, 15);
    send_frame("long", 17'h1F0F0, 17);

`ifdef MCP4922_RX_LDAC_EN
    begin
      int lat;
      do_reset();
      set_ldac(1'b1);
      send_frame("held", 17'h03555, 16);
      chk_val("held_dac_a", {20'd0, dac_a}, 32'd0);
      ldac_n = 1'b0;
      lat = 0;
      for (int k = 1; k <= SS + 5; k++) begin
        @(negedge clk);
        if (dac_a == 12'h555 && lat == 0) lat = k;
      end
      model_xfer();
      chk_val("ldac_lat", lat, SS + 1);
      check_outs("ldac_rel");
    end
`endif

    cs_n = 1'b0;
    cyc(H);
    for (int i = 0; i < 8; i++) begin
      sdi = i[0];
      cyc(H);
      sck = 1'b1;
      cyc(H);
      sck = 1'b0;
    end
    reset = 1'b0;
    cyc(3);
    model_reset();
    check_outs("rst_mid");
    v0 = n_valid;
    e0 = n_err;
    reset = 1'b1;
    cyc(H);
    cs_n = 1'b1;
    cyc(H);
    send_frame("after_rst", 17'h03001, 16);
    chk_val("rst_total_valid", n_valid - v0, 32'd1);
    chk_val("rst_total_err", n_err - e0, 32'd0);

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) set_ldac(~ldac_n);
      w = 17'($urandom);
      case ($urandom_range(0, 5))
        0:       nb = 15;
        1:       nb = 17;
        default: nb = 16;
      endcase
      send_frame("rand", w, nb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/mcp4922_rx.md
# mcp4922_rx

Receive-side model of the MCP4922 dual 12-bit DAC serial interface. The block oversamples an SPI bus (sck/sdi/cs_n plus ldac_n) on the system clock and decodes 16-bit write frames. It holds per-channel input and output registers and reports each accepted or rejected frame. It sits at the far end of the DAC driver, on the board-level SPI pins in loopback builds and in the simulation bench, so that DAC traffic generated by the vector pipeline can be checked on real signals.

## Interface
- SYNC_STAGES, 2, flip-flop stages per synchronizer on sck, sdi, cs_n, ldac_n; legal values are 2..4.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sck  in  1  SPI clock, mode 0,0; sdi is sampled on the rising edge.
- sdi  in  1  serial data, MSB first.
- cs_n  in  1  frame select, active low.
- ldac_n  in  1  latch strobe, active low, level-sensitive.
- dac_a  out  12  channel A output register.
- dac_b  out  12  channel B output register.
- gain2_a, gain2_b  out  1 each  1 = 2x gain selected (GA_n = 0).
- shdn_a, shdn_b  out  1 each  1 = channel is in shutdown (SHDN_n = 0).
- frame_valid  out  1  one-cycle pulse when a frame is accepted.
- frame_axis  out  1  channel of the last accepted frame (0 = A, 1 = B).
- frame_err  out  1  one-cycle pulse when a frame is rejected.

## Operation
- All four SPI inputs pass through SYNC_STAGES-deep synchronizers. A further register on the synchronized sck and cs_n provides edge detection.
- Frame start, cs_n falling edge: clear the shift register and the bit counter.
- Bit capture, sck rising edge while synchronized cs_n = 0: shift sdi into a 16-bit shift register and increment the 5-bit bit counter. The counter saturates at 17.
- sck edges while cs_n = 1 are ignored.
- Frame end, cs_n rising edge:
  - count == 16: accept the frame.
  - any other count: pulse frame_err. No register changes.
- Frame decode:
  - bit 15 selects the channel (0 = A, 1 = B).
  - bit 14 is BUF, decoded but not stored.
  - bit 13 is GA_n.
  - bit 12 is SHDN_n.
  - bits 11:0 are the data.
- Accept actions:
  - load the selected channel's input register with data, gain2 = ~GA_n and shdn = ~SHDN_n.
  - set frame_axis to the frame's channel.
  - pulse frame_valid.
- Transfer to outputs: while synchronized ldac_n = 0, both channels' output registers (dac_x, gain2_x, shdn_x) copy their input registers every cycle.
- Accept and ldac_n = 0 in the same cycle: the output register takes the newly accepted frame value, not the old input register.
- Data in shutdown: shdn does not alter the dac_x value. It is a flag only.
- State machine:
  - IDLE: cs_n high. On cs_n falling, go to SHIFT.
  - SHIFT: on cs_n rising, go to DONE.
  - DONE: one cycle; perform accept or reject, then go to IDLE.
  - A cs_n falling edge seen in DONE is honoured: go to SHIFT, with the counter cleared after DONE's action.
- Reset: asserting reset at any time, including mid-frame, returns to IDLE and discards the partial frame. The first frame after reset release is decoded only if cs_n falls after release.

## Timing
- Reset values: dac_a = dac_b = 0, gain2_a = gain2_b = 0, shdn_a = shdn_b = 0, frame_valid = 0, frame_axis = 0, frame_err = 0. The internal input registers are also 0.
- Input constraints:
  - sck high and low phases must each be ≥ SYNC_STAGES+1 clk periods; faster sck is unsupported.
  - sdi must be stable ≥ 1 clk before and after the sck rising edge as seen at the pins.
- frame_valid / frame_err latency: asserted exactly SYNC_STAGES+2 clk cycles after the first clk edge that samples cs_n = 1 at the pin. Pulse width is 1 cycle.
- Transfer latency:
  - Frame accepted while ldac_n is held low: dac_x updates in the same cycle as frame_valid.
  - ldac_n falls later: dac_x updates SYNC_STAGES+1 cycles after ldac_n is first sampled low.
- Minimum cs_n-high gap between frames: 2 clk cycles after synchronization.

## Configuration
- MCP4922_RX_LDAC_EN defined: ldac_n behaves as specified above.
- MCP4922_RX_LDAC_EN undefined:
  - ldac_n port is present but ignored; its synchronizer is removed.
  - output registers update on frame accept, in the same cycle as frame_valid.
  - input registers still exist so that the decode path is identical.

## Test plan
- Accept to channel A: ldac_n = 0, send frame 0x3ABC → frame_valid pulse, frame_axis = 0, dac_a = 0xABC, gain2_a = 0, shdn_a = 0, dac_b = 0.
- Decode GA_n/SHDN_n on channel B: send 0x8123 → dac_b = 0x123, gain2_b = 1, shdn_b = 1, frame_axis = 1.
- Short frame: send 15 bits, then raise cs_n → frame_err pulse, no frame_valid, all outputs unchanged.
- Long frame: send 17 bits → frame_err pulse, no frame_valid, all outputs unchanged.
- Held latch (LDAC_EN defined): ldac_n = 1, send 0x3555 → dac_a stays 0. Then drop ldac_n → dac_a = 0x555 SYNC_STAGES+1 cycles later.
- Reset mid-frame: assert reset after 8 bits, release, then send full frame 0x3001 → only one frame_valid, dac_a = 0x001, no frame_err.
